// File: rtl/half_adder_core.sv
// rtl/half_adder_core.sv - combinational unsigned add of two operands, no carry-in
//
// Ports:
//   a     [WIDTH-1:0]  operand A, unsigned
//   b     [WIDTH-1:0]  operand B, unsigned
//   sum   [WIDTH-1:0]  (a + b) mod 2^WIDTH
//   carry              bit WIDTH of a + b

module half_adder_core #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  // Zero-extend both operands so the carry falls out as the MSB of the
  // WIDTH+1 bit result; for WIDTH=1 this reduces to XOR / AND.
  logic [WIDTH:0] full_sum;

  assign full_sum = {1'b0, a} + {1'b0, b};
  assign sum      = full_sum[WIDTH-1:0];
  assign carry    = full_sum[WIDTH];

endmodule

// File: rtl/half_adder.sv
// rtl/half_adder.sv - registered half adder, one-cycle latency, one op per clock
//
// Ports:
//   clk_in     single clock, rising edge
//   rst_n_in   asynchronous active-low reset
//   a_in       [WIDTH-1:0] operand A, unsigned
//   b_in       [WIDTH-1:0] operand B, unsigned
//   valid_in   operands valid this cycle
//   sum_out    [WIDTH-1:0] registered sum, held while valid_in=0
//   car_out    registered carry-out, held while valid_in=0
//   valid_out  sum_out/car_out carry a fresh result this cycle

module half_adder #(
  parameter int WIDTH = 1
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             valid_in,
  output logic [WIDTH-1:0] sum_out,
  output logic             car_out,
  output logic             valid_out
);

  logic [WIDTH-1:0] core_sum;
  logic             core_carry;

  half_adder_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a     (a_in),
    .b     (b_in),
    .sum   (core_sum),
    .carry (core_carry)
  );

  // Result registers load only on valid_in, so operand values (including
  // X/Z) presented while valid_in=0 never reach the outputs.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sum_out   <= '0;
      car_out   <= 1'b0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= valid_in;
      if (valid_in) begin
        sum_out <= core_sum;
        car_out <= core_carry;
      end
    end
  end

endmodule

// File: tb/tb_half_adder.sv
// tb/tb_half_adder.sv - self-checking bench for half_adder at WIDTH=1 and WIDTH=8

module tb_half_adder;

  logic       clk;
  logic       rst_n;
  logic [0:0] a1, b1, s1;
  logic       v1, c1, vo1;
  logic [7:0] a8, b8, s8;
  logic       v8, c8, vo8;

  int tests_run = 0;
  int tests_failed = 0;

  half_adder #(.WIDTH(1)) dut1 (
    .clk_in    (clk),
    .rst_n_in  (rst_n),
    .a_in      (a1),
    .b_in      (b1),
    .valid_in  (v1),
    .sum_out   (s1),
    .car_out   (c1),
    .valid_out (vo1)
  );

  half_adder #(.WIDTH(8)) dut8 (
    .clk_in    (clk),
    .rst_n_in  (rst_n),
    .a_in      (a8),
    .b_in      (b8),
    .valid_in  (v8),
    .sum_out   (s8),
    .car_out   (c8),
    .valid_out (vo8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       v;
    logic [7:0] s;
    logic       c;
    logic       ov;
  } vec_t;

  vec_t t1[6];
  vec_t t8[8];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] ra, rb, es;
  logic       rv, ec;

  initial begin
    // WIDTH=1 vectors: four input combos, then hold with valid low.
    t1[0] = '{8'd0, 8'd0, 1'b1, 8'd0, 1'b0, 1'b1};
    t1[1] = '{8'd0, 8'd1, 1'b1, 8'd1, 1'b0, 1'b1};
    t1[2] = '{8'd1, 8'd0, 1'b1, 8'd1, 1'b0, 1'b1};
    t1[3] = '{8'd1, 8'd1, 1'b1, 8'd0, 1'b1, 1'b1};
    t1[4] = '{8'd0, 8'd0, 1'b0, 8'd0, 1'b1, 1'b0};
    t1[5] = '{8'd1, 8'd0, 1'b0, 8'd0, 1'b1, 1'b0};
    // WIDTH=8 vectors: overflow boundaries, plain sums, hold.
    t8[0] = '{8'hFF, 8'h01, 1'b1, 8'h00, 1'b1, 1'b1};
    t8[1] = '{8'hFF, 8'hFF, 1'b1, 8'hFE, 1'b1, 1'b1};
    t8[2] = '{8'h12, 8'h34, 1'b1, 8'h46, 1'b0, 1'b1};
    t8[3] = '{8'h80, 8'h80, 1'b1, 8'h00, 1'b1, 1'b1};
    t8[4] = '{8'h7F, 8'h01, 1'b1, 8'h80, 1'b0, 1'b1};
    t8[5] = '{8'hAA, 8'h55, 1'b0, 8'h80, 1'b0, 1'b0};
    t8[6] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b0, 1'b1};
    t8[7] = '{8'hFE, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b1};

    rst_n = 1'b0;
    a1 = '0; b1 = '0; v1 = 1'b0;
    a8 = '0; b8 = '0; v8 = 1'b0;
    tick();
    chk("reset_w1", {13'd0, s1, c1, vo1}, 16'd0);
    chk("reset_w8", {6'd0, s8, c8, vo8}, 16'd0);
    #3 rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      a1 = t1[i].a[0:0]; b1 = t1[i].b[0:0]; v1 = t1[i].v;
      tick();
      chk($sformatf("w1_vec%0d", i), {13'd0, s1, c1, vo1},
          {13'd0, t1[i].s[0:0], t1[i].c, t1[i].ov});
    end
    v1 = 1'b0;

    for (int i = 0; i < 8; i++) begin
      a8 = t8[i].a; b8 = t8[i].b; v8 = t8[i].v;
      tick();
      chk($sformatf("w8_vec%0d", i), {6'd0, s8, c8, vo8},
          {6'd0, t8[i].s, t8[i].c, t8[i].ov});
    end
    v8 = 1'b0;

    // Mid-cycle reset while car_out=1 clears outputs without a clock edge.
    a1 = 1'b1; b1 = 1'b1; v1 = 1'b1;
    tick();
    chk("pre_reset_car", {13'd0, s1, c1, vo1}, {13'd0, 1'b0, 1'b1, 1'b1});
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_w1", {13'd0, s1, c1, vo1}, 16'd0);
    chk("async_reset_w8", {6'd0, s8, c8, vo8}, 16'd0);
    tick();
    chk("reset_held_edge", {13'd0, s1, c1, vo1}, 16'd0);
    #3;
    rst_n = 1'b1;
    a1 = 1'b0; b1 = 1'b1; v1 = 1'b1;
    tick();
    chk("post_reset_01", {13'd0, s1, c1, vo1}, {13'd0, 1'b1, 1'b0, 1'b1});
    v1 = 1'b0;
    tick();
    chk("post_reset_hold", {13'd0, s1, c1, vo1}, {13'd0, 1'b1, 1'b0, 1'b0});

    // Random valid pattern on WIDTH=8 against a simple adder model.
    es = s8; ec = c8;
    for (int n = 0; n < 1000; n++) begin
      ra = 8'($urandom); rb = 8'($urandom); rv = 1'($urandom_range(0, 1));
      a8 = ra; b8 = rb; v8 = rv;
      if (rv) {ec, es} = {1'b0, ra} + {1'b0, rb};
      tick();
      chk($sformatf("rand%0d", n), {6'd0, s8, c8, vo8}, {6'd0, es, ec, rv});
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
